// File: rtl/p_uart_send_pkg.sv
// Shared constants for the 64-bit UART frame transmitter and its receiver.
// Optional feature macro: P_UART_SEND_CHECKSUM_EN (appends an XOR checksum byte).
package p_uart_send_pkg;

  // FSM state encoding, shared by the byte serialiser and the sequencer
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_START = S_START,
    ST_DATA  = S_DATA,
    ST_STOP  = S_STOP,
    ST_DONE  = S_DONE
  } state_t;

  localparam int DATA_BYTES = 8;

`ifdef P_UART_SEND_CHECKSUM_EN
  localparam int NUM_BYTES = 9;
`else
  localparam int NUM_BYTES = 8;
`endif

  localparam int CNT_W = 16;

  // Clock cycles per serial bit; must land in 2..65535 to fit the 16-bit counter
  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  // XOR of the eight bytes of a word, used as the trailing checksum byte
  function automatic logic [7:0] xor_bytes(input logic [63:0] word);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++) begin
      acc = acc ^ word[8*i +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/p_uart_send_byte_tx.sv
// 8N1 serialiser for one byte. Accepts a new byte either while idle or in the
// final cycle of the stop bit, so consecutive bytes go out with no gap.
// State | meaning
// IDLE  | line high, waiting for tx_start
// START | start bit (low) for BPS_CNT cycles
// DATA  | eight data bits, LSB first, BPS_CNT cycles each
// STOP  | stop bit (high) for BPS_CNT cycles
module uart_byte_tx
  import p_uart_send_pkg::*;
#(
  parameter int BPS_CNT = 10
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       uart_txd,
  output logic       tx_idle
);

  localparam logic [CNT_W-1:0] BPS_LAST = CNT_W'(BPS_CNT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_byte;
  logic             r_txd;
  logic             w_bit_end;

  assign w_bit_end = (r_clk_cnt == BPS_LAST);

  // Ready for tx_start: idle, or the last cycle of a stop bit (back-to-back)
  assign tx_idle  = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end);
  assign uart_txd = r_txd;

  // Bit-period counter, bit index and registered line driver
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_byte    <= '0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_txd     <= 1'b1;
          r_clk_cnt <= '0;
          if (tx_start) begin
            r_byte  <= tx_byte;
            r_state <= ST_START;
            r_txd   <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
            r_txd     <= r_byte[0];
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_byte[r_bit_idx + 3'd1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (tx_start) begin
              r_byte  <= tx_byte;
              r_state <= ST_START;
              r_txd   <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_txd   <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_clk_cnt <= '0;
          r_txd     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/p_uart_send.sv
// 64-bit parallel UART transmitter: latches a word and sends it as eight
// consecutive 8N1 bytes, LSB byte first. Byte sequencing and the done pulse
// live here; bit timing lives in uart_byte_tx.
// Optional feature macro: P_UART_SEND_CHECKSUM_EN (ninth byte = XOR of the eight).
// State | meaning
// IDLE  | waiting for send_en
// START | word latched, first byte launched on the next edge
// DATA  | bytes in flight, next byte launched at each stop-bit end
// DONE  | one-cycle send_done pulse
module p_uart_send
  import p_uart_send_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        send_en,
  input  logic [63:0] send_data,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        send_done
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [3:0] LAST_COUNT = 4'(NUM_BYTES);

  state_t      r_state;
  logic [63:0] r_shift;
  logic [3:0]  r_byte_idx;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  w_fill;
  logic        w_tx_start;
  logic        w_tx_idle;

`ifdef P_UART_SEND_CHECKSUM_EN
  logic [7:0] r_csum;

  // Checksum of the word captured at acceptance; shifted in behind the data
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_csum <= '0;
    end else if ((r_state == ST_IDLE) && send_en) begin
      r_csum <= xor_bytes(send_data);
    end
  end

  assign w_fill = r_csum;
`else
  assign w_fill = 8'h00;
`endif

  // Launch a byte on the first edge after acceptance, then at each stop-bit end
  assign w_tx_start = (r_state == ST_START) ||
                      ((r_state == ST_DATA) && w_tx_idle && (r_byte_idx != LAST_COUNT));

  // Byte sequencer with registered busy/done outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (send_en) begin
            r_shift    <= send_data;
            r_byte_idx <= '0;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          r_busy     <= 1'b1;
          r_shift    <= {w_fill, r_shift[63:8]};
          r_byte_idx <= r_byte_idx + 4'd1;
          r_state    <= ST_DATA;
        end
        ST_DATA: begin
          if (w_tx_start) begin
            r_shift    <= {w_fill, r_shift[63:8]};
            r_byte_idx <= r_byte_idx + 4'd1;
          end else if (w_tx_idle) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  uart_byte_tx #(
    .BPS_CNT (BPS_CNT)
  ) u_byte_tx (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tx_start  (w_tx_start),
    .tx_byte   (r_shift[7:0]),
    .uart_txd  (uart_txd),
    .tx_idle   (w_tx_idle)
  );

  assign tx_busy   = r_busy;
  assign send_done = r_done;

endmodule

// File: doc/p_uart_send.md
# p_uart_send

Parallel UART transmitter: latches one 64-bit word and serialises it as 8 consecutive 8N1 UART bytes, least-significant byte first. It is the transmit-side counterpart of the 64-bit UART frame receiver, and its framing matches that receiver. A `p_uart_recv` → `p_uart_send` loopback returns the same 64-bit word unchanged. It sits between the user logic that produces `uart_data`/`uart_done`-style words and the board TXD pin.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `UART_BPS`, 9600: baud rate. The localparam `BPS_CNT = CLK_FREQ/UART_BPS` (integer divide) is the clock cycles per bit; it must satisfy 2 ≤ `BPS_CNT` ≤ 65535.
- `sys_clk`  in  1: system clock. The block uses one clock domain only.
- `sys_rst_n`  in  1: reset, asynchronous and active-low.
- `send_en`  in  1: one-cycle request. It is sampled only while idle.
- `send_data`  in  64: word to send. It is captured in the cycle `send_en` is accepted.
- `uart_txd`  out  1: serial output. It idles high.
- `tx_busy`  out  1: high while a frame is in progress.
- `send_done`  out  1: one-cycle pulse when the last stop bit completes.

## Operation
- **Reset values:**
  - `uart_txd` = 1.
  - `tx_busy` = 0.
  - `send_done` = 0.
  - The latch, byte index, bit index and clock counter are all cleared.
  - The FSM is in IDLE.
- **FSM states:** IDLE, START, DATA, STOP, DONE.
- **IDLE:**
  - When `send_en` = 1, latch `send_data` into a 64-bit shift register and set byte index = 0.
  - Go to START. `tx_busy` rises on the next cycle.
- **START:**
  - Drive `uart_txd` = 0 for `BPS_CNT` cycles, then go to DATA with bit index = 0.
- **DATA:**
  - Drive bit [bit index] of the current byte, LSB first, for `BPS_CNT` cycles per bit.
  - After bit 7, go to STOP.
- **STOP:**
  - Drive `uart_txd` = 1 for `BPS_CNT` cycles.
  - If byte index < 7 (or < 8 with the checksum enabled), increment the byte index and go to START. There is no idle gap between bytes.
  - Otherwise go to DONE.
- **DONE:**
  - Lasts one cycle: `send_done` = 1, `tx_busy` = 0, `uart_txd` = 1.
  - Returns to IDLE.
- **Bit-period counter:**
  - `clk_cnt` is 16 bits and counts 0..`BPS_CNT`-1.
  - It wraps to 0 on each bit boundary, which advances the bit or state.
- **Byte order:** byte k = `send_data[8k+7:8k]`, sent in order k = 0..7.
- **Boundary rules:**
  - `send_en` while busy (START/DATA/STOP/DONE) is ignored and not queued.
  - `send_data` changes after acceptance have no effect.
  - `send_en` asserted in the cycle DONE returns to IDLE is not accepted. Acceptance happens only in IDLE.
  - Reset mid-frame aborts immediately: `uart_txd` returns to 1 and no `send_done` is issued.

## Timing
- **Start latency:** `send_en` sampled at edge N → `uart_txd` falls and `tx_busy` rises at edge N+1.
- **Frame length:** 80·`BPS_CNT` cycles from the first start-bit edge to the end of the last stop bit (90·`BPS_CNT` with the checksum).
- **Frame end:** `send_done` is high for exactly one cycle immediately after the final stop-bit period, and `tx_busy` is low in that same cycle.
- **Earliest next request:** the cycle after `send_done`.
- **Output registration:** `uart_txd` is a registered output with no combinational path from the inputs.

## Configuration
- `P_UART_SEND_CHECKSUM_EN` defined:
  - A ninth byte is appended after byte 7, with identical START/DATA/STOP framing.
  - Its value is the XOR of the eight data bytes, computed from the latched word.
- Not defined: exactly 8 bytes are sent, and no checksum logic is present.

## Structure
- **Shared package/header:**
  - FSM state encoding (3-bit localparams).
  - The `BPS_CNT` derivation.
  - Byte-count constants, 8 or 9 depending on the macro.
  - The receiver uses the same constants.
- **Sub-module `uart_byte_tx`:**
  - Serialises one byte with 8N1 framing.
  - Interface: `sys_clk`, `sys_rst_n`, `tx_start`, `tx_byte[7:0]`, `uart_txd`, `tx_idle`.
  - The top level then holds the byte sequencer and the DONE pulse.
  - Overall timing must still meet the zero-gap rule.

## Test plan
Bench setup: `CLK_FREQ`=1000000, `UART_BPS`=100000, giving `BPS_CNT`=10.
- **Single frame:** `send_en` with `send_data`=64'h0807060504030201.
  - The decoded bytes are 01,02,…,08 in order.
  - Each bit lasts 10 cycles.
  - `send_done` pulses exactly 801 cycles after acceptance.
- **Loopback:** `uart_txd` → `p_uart_rxd` with `send_data`=64'hDEADBEEFCAFEF00D.
  - The receiver `uart_data` equals 64'hDEADBEEFCAFEF00D.
- **Busy rejection:** a second `send_en` with different data at cycle 300.
  - It is ignored: only the first word is transmitted, with one `send_done`.
- **Reset mid-frame:** `sys_rst_n` low at cycle 400.
  - `uart_txd`=1, `tx_busy`=0 and `send_done`=0 immediately.
  - A new `send_en` after release sends a full, correct frame.
- **Back-to-back:** `send_en` in the cycle after `send_done`.
  - It is accepted, and the second frame starts on the next edge.
- **Checksum build:** with `P_UART_SEND_CHECKSUM_EN` defined and `send_data`=64'h0807060504030201.
  - A ninth byte 08 is sent (the XOR of the eight bytes).
  - `send_done` pulses at cycle 901.
